// File: rtl/vx_gpu_ext_dispatch_pkg.sv
// Shared GPU control types: warp-control payload layout and the commit entry
// layout used by the dispatch/commit path at its default configuration.
package gpu_types;

  localparam int GPU_NUM_THREADS = 4;
  localparam int GPU_NUM_WARPS   = 4;
  localparam int GPU_NW_BITS     = 2;
  localparam int GPU_NR_BITS     = 5;
  localparam int GPU_UUID_BITS   = 44;
  localparam int GPU_BAR_IDW     = 7;
  localparam int GPU_BAR_SIZEW   = 4;

  typedef struct packed {
    logic                       valid;
    logic [GPU_NUM_THREADS-1:0] tmask;
  } gpu_tmc_t;

  typedef struct packed {
    logic                     valid;
    logic [GPU_NUM_WARPS-1:0] wmask;
    logic [31:0]              pc;
  } gpu_wspawn_t;

  typedef struct packed {
    logic                       valid;
    logic                       diverged;
    logic [GPU_NUM_THREADS-1:0] then_tmask;
    logic [GPU_NUM_THREADS-1:0] else_tmask;
  } gpu_split_t;

  typedef struct packed {
    logic                     valid;
    logic [GPU_BAR_IDW-1:0]   id;
    logic [GPU_BAR_SIZEW-1:0] size_m1;
  } gpu_barrier_t;

  typedef struct packed {
    gpu_tmc_t     tmc;
    gpu_wspawn_t  wspawn;
    gpu_split_t   split;
    gpu_barrier_t barrier;
  } gpu_wctl_t;

  localparam int GPU_WCTL_DATAW = $bits(gpu_wctl_t);
  localparam int GPU_RSP_DATAW  = (GPU_NUM_THREADS * 32 > GPU_WCTL_DATAW) ?
                                  GPU_NUM_THREADS * 32 : GPU_WCTL_DATAW;

  typedef struct packed {
    logic [GPU_UUID_BITS-1:0]   uuid;
    logic [GPU_NW_BITS-1:0]     wid;
    logic [GPU_NUM_THREADS-1:0] tmask;
    logic [31:0]                pc;
    logic [GPU_NR_BITS-1:0]     rd;
    logic                       wb;
    logic [GPU_RSP_DATAW-1:0]   data;
    logic                       is_wctl;
  } gpu_commit_entry_t;

endpackage

// File: rtl/vx_gpu_ext_dispatch_arb.sv
// Round-robin arbiter: priority starts at the pointer and wraps; the pointer
// moves past the winner only on a granted cycle.
module vx_gpu_rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          i_enable,
  input  logic [N-1:0]  i_req,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_idx;
  logic [IW-1:0] w_cand;
  logic          w_found;

  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = '0;
    for (int i = 0; i < N; i++) begin
      w_cand = IW'((int'(r_ptr) + i) % N);
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
  end

  assign o_valid = i_enable && w_found;
  assign o_idx   = w_idx;

  always_comb begin
    o_grant = '0;
    if (o_valid) o_grant[w_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_ptr <= '0;
    end else if (o_valid) begin
      r_ptr <= (w_idx == IW'(N - 1)) ? '0 : w_idx + IW'(1);
    end
  end

endmodule

// File: rtl/vx_gpu_ext_dispatch.sv
// GPU dispatch/commit: routes requests to extension channels or warp control,
// merges responses round-robin into a commit FIFO, bounds in-flight work per channel.
module vx_gpu_ext_dispatch
  import gpu_types::*;
#(
  parameter int NUM_EXT     = 2,
  parameter int NUM_THREADS = 4,
  parameter int NW_BITS     = 2,
  parameter int NR_BITS     = 5,
  parameter int UUID_BITS   = 44,
  parameter int WCTL_DATAW  = GPU_WCTL_DATAW,
  parameter int REQ_DATAW   = 256,
  parameter int RSP_DEPTH   = 4,
  parameter int MAX_PENDING = 4,
  parameter int SELW        = $clog2(NUM_EXT + 1)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [SELW-1:0]                    req_sel,
  input  logic [UUID_BITS-1:0]               req_uuid,
  input  logic [NW_BITS-1:0]                 req_wid,
  input  logic [NUM_THREADS-1:0]             req_tmask,
  input  logic [31:0]                        req_PC,
  input  logic [NR_BITS-1:0]                 req_rd,
  input  logic                               req_wb,
  input  logic [REQ_DATAW-1:0]               req_data,
  input  logic [WCTL_DATAW-1:0]              req_wctl_data,
  output logic [NUM_EXT-1:0]                 ext_req_valid,
  input  logic [NUM_EXT-1:0]                 ext_req_ready,
  output logic [UUID_BITS-1:0]               ext_req_uuid,
  output logic [NW_BITS-1:0]                 ext_req_wid,
  output logic [NUM_THREADS-1:0]             ext_req_tmask,
  output logic [31:0]                        ext_req_PC,
  output logic [NR_BITS-1:0]                 ext_req_rd,
  output logic                               ext_req_wb,
  output logic [REQ_DATAW-1:0]               ext_req_data,
  input  logic [NUM_EXT-1:0]                 ext_rsp_valid,
  output logic [NUM_EXT-1:0]                 ext_rsp_ready,
  input  logic [NUM_EXT*UUID_BITS-1:0]       ext_rsp_uuid,
  input  logic [NUM_EXT*NW_BITS-1:0]         ext_rsp_wid,
  input  logic [NUM_EXT*NUM_THREADS-1:0]     ext_rsp_tmask,
  input  logic [NUM_EXT*32-1:0]              ext_rsp_PC,
  input  logic [NUM_EXT*NR_BITS-1:0]         ext_rsp_rd,
  input  logic [NUM_EXT-1:0]                 ext_rsp_wb,
  input  logic [NUM_EXT*NUM_THREADS*32-1:0]  ext_rsp_data,
  output logic                               commit_valid,
  input  logic                               commit_ready,
  output logic [UUID_BITS-1:0]               commit_uuid,
  output logic [NW_BITS-1:0]                 commit_wid,
  output logic [NUM_THREADS-1:0]             commit_tmask,
  output logic [31:0]                        commit_PC,
  output logic [NR_BITS-1:0]                 commit_rd,
  output logic                               commit_wb,
  output logic [NUM_THREADS*32-1:0]          commit_data,
  output logic                               commit_eop,
  output logic                               warp_ctl_valid,
  output logic [NW_BITS-1:0]                 warp_ctl_wid,
  output logic [WCTL_DATAW-1:0]              warp_ctl_data,
  output logic                               busy
);

  localparam int DW        = NUM_THREADS * 32;
  localparam int RSP_DATAW = (DW > WCTL_DATAW) ? DW : WCTL_DATAW;
  localparam int NSRC      = NUM_EXT + 1;
  localparam int IW        = $clog2(NSRC);
  localparam int PW        = $clog2(MAX_PENDING + 1);
  localparam int AW        = $clog2(RSP_DEPTH);

  typedef struct packed {
    logic [UUID_BITS-1:0]   uuid;
    logic [NW_BITS-1:0]     wid;
    logic [NUM_THREADS-1:0] tmask;
    logic [31:0]            pc;
    logic [NR_BITS-1:0]     rd;
    logic                   wb;
    logic [RSP_DATAW-1:0]   data;
    logic                   is_wctl;
  } entry_t;

  logic               w_sel_wctl;
  logic [NUM_EXT-1:0] w_credit_ok;
  logic [NUM_EXT-1:0] w_req_fire;
  logic [NUM_EXT-1:0] w_rsp_fire;
  logic [NSRC-1:0]    w_arb_req;
  logic [NSRC-1:0]    w_grant;
  logic [IW-1:0]      w_grant_idx;
  logic               w_push;
  logic               w_pop;
  logic               w_empty;
  logic               w_full;
  entry_t             w_push_entry;
  entry_t             w_head;

  logic [PW-1:0]      r_pending [NUM_EXT];
  entry_t             r_mem [RSP_DEPTH];
  logic [AW:0]        r_wptr;
  logic [AW:0]        r_rptr;

  assign w_sel_wctl = (req_sel == SELW'(NUM_EXT));

  // Out-of-range selectors are accepted and dropped.
  always_comb begin
    w_credit_ok   = '0;
    ext_req_valid = '0;
    req_ready     = 1'b1;
    for (int k = 0; k < NUM_EXT; k++) begin
      w_credit_ok[k] = (r_pending[k] < PW'(MAX_PENDING));
      if (req_sel == SELW'(k)) begin
        ext_req_valid[k] = req_valid && w_credit_ok[k];
        req_ready        = ext_req_ready[k] && w_credit_ok[k];
      end
    end
    if (w_sel_wctl) req_ready = w_grant[NUM_EXT];
  end

  assign ext_req_uuid  = req_uuid;
  assign ext_req_wid   = req_wid;
  assign ext_req_tmask = req_tmask;
  assign ext_req_PC    = req_PC;
  assign ext_req_rd    = req_rd;
  assign ext_req_wb    = req_wb;
  assign ext_req_data  = req_data;

  assign w_arb_req = {req_valid && w_sel_wctl, ext_rsp_valid};

  // Enable uses only the registered full flag, so commit_ready never reaches the inputs.
  vx_gpu_rr_arbiter #(
    .N (NSRC)
  ) u_arb (
    .clk      (clk),
    .rst_b    (reset),
    .i_enable (!w_full),
    .i_req    (w_arb_req),
    .o_grant  (w_grant),
    .o_idx    (w_grant_idx),
    .o_valid  (w_push)
  );

  assign ext_rsp_ready = w_grant[NUM_EXT-1:0];

  always_comb begin
    w_push_entry = '0;
    if (w_grant_idx == IW'(NUM_EXT)) begin
      w_push_entry.uuid    = req_uuid;
      w_push_entry.wid     = req_wid;
      w_push_entry.tmask   = req_tmask;
      w_push_entry.pc      = req_PC;
      w_push_entry.data    = RSP_DATAW'(req_wctl_data);
      w_push_entry.is_wctl = 1'b1;
    end else begin
      for (int k = 0; k < NUM_EXT; k++) begin
        if (w_grant_idx == IW'(k)) begin
          w_push_entry.uuid  = ext_rsp_uuid[k*UUID_BITS +: UUID_BITS];
          w_push_entry.wid   = ext_rsp_wid[k*NW_BITS +: NW_BITS];
          w_push_entry.tmask = ext_rsp_tmask[k*NUM_THREADS +: NUM_THREADS];
          w_push_entry.pc    = ext_rsp_PC[k*32 +: 32];
          w_push_entry.rd    = ext_rsp_rd[k*NR_BITS +: NR_BITS];
          w_push_entry.wb    = ext_rsp_wb[k];
          w_push_entry.data  = RSP_DATAW'(ext_rsp_data[k*DW +: DW]);
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_EXT; k++) begin
      w_req_fire[k] = ext_req_valid[k] && ext_req_ready[k];
      w_rsp_fire[k] = ext_rsp_valid[k] && w_grant[k];
    end
  end

  // A stray response at zero credits leaves the counter at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_EXT; k++) r_pending[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_EXT; k++) begin
        if (w_req_fire[k] && !w_rsp_fire[k]) begin
          r_pending[k] <= r_pending[k] + PW'(1);
        end else if (!w_req_fire[k] && w_rsp_fire[k] && (r_pending[k] != '0)) begin
          r_pending[k] <= r_pending[k] - PW'(1);
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_EXT; k++) begin : g_credit_chk
    a_rsp_without_credit: assert property (@(posedge clk) disable iff (!reset)
      w_rsp_fire[k] |-> (r_pending[k] != '0));
  end

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = !w_empty && commit_ready;
  assign w_head  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= w_push_entry;
  end

  assign commit_valid   = !w_empty;
  assign commit_uuid    = w_head.uuid;
  assign commit_wid     = w_head.wid;
  assign commit_tmask   = w_head.tmask;
  assign commit_PC      = w_head.pc;
  assign commit_rd      = w_head.rd;
  assign commit_wb      = w_head.wb;
  assign commit_data    = w_head.data[DW-1:0];
  assign commit_eop     = 1'b1;
  assign warp_ctl_valid = w_pop && w_head.is_wctl;
  assign warp_ctl_wid   = w_head.wid;
  assign warp_ctl_data  = w_head.data[WCTL_DATAW-1:0];

  always_comb begin
    busy = !w_empty;
    for (int k = 0; k < NUM_EXT; k++) begin
      if (r_pending[k] != '0) busy = 1'b1;
    end
  end

endmodule

// File: tb/tb_vx_gpu_ext_dispatch.sv
// Directed bench for vx_gpu_ext_dispatch at default parameters.
module tb_vx_gpu_ext_dispatch;

  localparam int NE = 2;
  localparam int NT = 4;
  localparam int NW = 2;
  localparam int NR = 5;
  localparam int UB = 44;
  localparam int WD = 64;
  localparam int RD = 256;
  localparam int SW = 2;
  localparam int DW = NT * 32;

  logic clk = 1'b0;
  logic reset;
  logic req_valid, req_ready;
  logic [SW-1:0] req_sel;
  logic [UB-1:0] req_uuid;
  logic [NW-1:0] req_wid;
  logic [NT-1:0] req_tmask;
  logic [31:0] req_PC;
  logic [NR-1:0] req_rd;
  logic req_wb;
  logic [RD-1:0] req_data;
  logic [WD-1:0] req_wctl_data;
  logic [NE-1:0] ext_req_valid, ext_req_ready;
  logic [UB-1:0] ext_req_uuid;
  logic [NW-1:0] ext_req_wid;
  logic [NT-1:0] ext_req_tmask;
  logic [31:0] ext_req_PC;
  logic [NR-1:0] ext_req_rd;
  logic ext_req_wb;
  logic [RD-1:0] ext_req_data;
  logic [NE-1:0] ext_rsp_valid, ext_rsp_ready;
  logic [NE*UB-1:0] ext_rsp_uuid;
  logic [NE*NW-1:0] ext_rsp_wid;
  logic [NE*NT-1:0] ext_rsp_tmask;
  logic [NE*32-1:0] ext_rsp_PC;
  logic [NE*NR-1:0] ext_rsp_rd;
  logic [NE-1:0] ext_rsp_wb;
  logic [NE*DW-1:0] ext_rsp_data;
  logic commit_valid, commit_ready;
  logic [UB-1:0] commit_uuid;
  logic [NW-1:0] commit_wid;
  logic [NT-1:0] commit_tmask;
  logic [31:0] commit_PC;
  logic [NR-1:0] commit_rd;
  logic commit_wb;
  logic [DW-1:0] commit_data;
  logic commit_eop;
  logic warp_ctl_valid;
  logic [NW-1:0] warp_ctl_wid;
  logic [WD-1:0] warp_ctl_data;
  logic busy;

  int n_chk = 0;
  int n_bad = 0;

  vx_gpu_ext_dispatch dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
    .req_uuid(req_uuid), .req_wid(req_wid), .req_tmask(req_tmask), .req_PC(req_PC),
    .req_rd(req_rd), .req_wb(req_wb), .req_data(req_data), .req_wctl_data(req_wctl_data),
    .ext_req_valid(ext_req_valid), .ext_req_ready(ext_req_ready),
    .ext_req_uuid(ext_req_uuid), .ext_req_wid(ext_req_wid), .ext_req_tmask(ext_req_tmask),
    .ext_req_PC(ext_req_PC), .ext_req_rd(ext_req_rd), .ext_req_wb(ext_req_wb),
    .ext_req_data(ext_req_data),
    .ext_rsp_valid(ext_rsp_valid), .ext_rsp_ready(ext_rsp_ready),
    .ext_rsp_uuid(ext_rsp_uuid), .ext_rsp_wid(ext_rsp_wid), .ext_rsp_tmask(ext_rsp_tmask),
    .ext_rsp_PC(ext_rsp_PC), .ext_rsp_rd(ext_rsp_rd), .ext_rsp_wb(ext_rsp_wb),
    .ext_rsp_data(ext_rsp_data),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_uuid(commit_uuid), .commit_wid(commit_wid), .commit_tmask(commit_tmask),
    .commit_PC(commit_PC), .commit_rd(commit_rd), .commit_wb(commit_wb),
    .commit_data(commit_data), .commit_eop(commit_eop),
    .warp_ctl_valid(warp_ctl_valid), .warp_ctl_wid(warp_ctl_wid),
    .warp_ctl_data(warp_ctl_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rsp(input int k, input logic [UB-1:0] uuid, input logic [DW-1:0] data);
    ext_rsp_uuid[k*UB +: UB]  = uuid;
    ext_rsp_wid[k*NW +: NW]   = NW'(k);
    ext_rsp_tmask[k*NT +: NT] = 4'hF;
    ext_rsp_PC[k*32 +: 32]    = 32'h1000 + 32'(k);
    ext_rsp_rd[k*NR +: NR]    = NR'(3 + k);
    ext_rsp_wb[k]             = 1'b1;
    ext_rsp_data[k*DW +: DW]  = data;
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 0; req_sel = '0; req_uuid = '0; req_wid = '0; req_tmask = '0;
    req_PC = '0; req_rd = '0; req_wb = 0; req_data = '0; req_wctl_data = '0;
    ext_req_ready = '0; ext_rsp_valid = '0; ext_rsp_uuid = '0; ext_rsp_wid = '0;
    ext_rsp_tmask = '0; ext_rsp_PC = '0; ext_rsp_rd = '0; ext_rsp_wb = '0;
    ext_rsp_data = '0; commit_ready = 0;

    #12;
    chk_eq("rst_commit_valid", commit_valid, 0);
    chk_eq("rst_warp_ctl_valid", warp_ctl_valid, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_ext_req_valid", ext_req_valid, 0);
    chk_eq("commit_eop", commit_eop, 1);
    tick();
    reset = 1'b1;
    tick();

    // single warp-control request
    req_valid = 1; req_sel = 2'd2; req_wid = 2'd2; req_tmask = 4'b1011;
    req_uuid = 44'hABC; req_PC = 32'h2000; req_rd = 5'd7; req_wb = 1;
    req_wctl_data = 64'hDEAD_BEEF_0123_4567;
    #1;
    chk_eq("wctl_req_ready", req_ready, 1);
    tick();
    req_valid = 0;
    chk_eq("wctl_commit_valid", commit_valid, 1);
    chk_eq("wctl_no_fire", warp_ctl_valid, 0);
    commit_ready = 1;
    #1;
    chk_eq("wctl_fire", warp_ctl_valid, 1);
    chk_eq("wctl_wid", warp_ctl_wid, 2);
    chk_eq("wctl_commit_wb", commit_wb, 0);
    chk_eq("wctl_commit_rd", commit_rd, 0);
    chk_eq("wctl_tmask", commit_tmask, 4'b1011);
    chk_eq("wctl_uuid", commit_uuid, 44'hABC);
    chk_eq("wctl_data", warp_ctl_data, 64'hDEAD_BEEF_0123_4567);
    chk_eq("wctl_commit_data", commit_data, {64'h0, 64'hDEAD_BEEF_0123_4567});
    tick();
    commit_ready = 0;
    chk_eq("wctl_drained", commit_valid, 0);
    chk_eq("wctl_idle_busy", busy, 0);

    // credit limit on channel 0
    req_valid = 1; req_sel = 2'd0; ext_req_ready = 2'b01;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_eq("cred_accept", req_ready, 1);
      chk_eq("cred_ext_valid", ext_req_valid, 2'b01);
      tick();
    end
    #1;
    chk_eq("cred_fifth_blocked", req_ready, 0);
    chk_eq("cred_fifth_ext_valid", ext_req_valid, 2'b00);
    chk_eq("cred_busy", busy, 1);
    set_rsp(0, 44'h123, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
    ext_rsp_valid = 2'b01;
    #1;
    chk_eq("cred_rsp_ready", ext_rsp_ready, 2'b01);
    tick();
    ext_rsp_valid = 2'b00;
    #1;
    chk_eq("cred_fifth_accept", req_ready, 1);
    tick();
    req_valid = 0;
    chk_eq("rsp_commit_valid", commit_valid, 1);
    chk_eq("rsp_uuid", commit_uuid, 44'h123);
    chk_eq("rsp_data", commit_data, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
    chk_eq("rsp_rd", commit_rd, 3);
    chk_eq("rsp_wb", commit_wb, 1);
    chk_eq("rsp_pc", commit_PC, 32'h1000);
    commit_ready = 1;
    #1;
    chk_eq("rsp_not_wctl", warp_ctl_valid, 0);
    tick();

    // round-robin: 3 credits on channel 1, one wctl to bring the pointer to 0
    req_valid = 1; req_sel = 2'd1; ext_req_ready = 2'b10;
    tick(); tick(); tick();
    req_sel = 2'd2;
    #1;
    chk_eq("rr_prime", req_ready, 1);
    tick();
    set_rsp(0, 44'h10, 128'hA0);
    set_rsp(1, 44'h11, 128'hA1);
    ext_rsp_valid = 2'b11;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk_eq("rr_grant", {req_ready, ext_rsp_ready}, 3'b001 << (c % 3));
      tick();
    end
    req_valid = 0; ext_rsp_valid = 2'b00;
    tick(); tick();
    chk_eq("rr_drained", commit_valid, 0);

    // simultaneous request and response on channel 1 (pending 1 -> 2 first)
    req_valid = 1; req_sel = 2'd1; ext_req_ready = 2'b10;
    tick();
    set_rsp(1, 44'h55, 128'hB5);
    ext_rsp_valid = 2'b10;
    #1;
    chk_eq("simul_req_ready", req_ready, 1);
    chk_eq("simul_rsp_ready", ext_rsp_ready, 2'b10);
    tick();
    ext_rsp_valid = 2'b00;
    #1; chk_eq("simul_after_0", req_ready, 1); tick();
    #1; chk_eq("simul_after_1", req_ready, 1); tick();
    #1; chk_eq("simul_after_2", req_ready, 0);
    req_valid = 0;
    tick();
    commit_ready = 0;
    chk_eq("simul_drained", commit_valid, 0);

    // FIFO full with 4 channel-1 responses
    ext_rsp_valid = 2'b10;
    for (int i = 0; i < 4; i++) begin
      set_rsp(1, 44'(100 + i), 128'(i + 1));
      #1;
      chk_eq("full_push_ready", ext_rsp_ready, 2'b10);
      tick();
    end
    ext_rsp_valid = 2'b01;
    set_rsp(0, 44'd200, 128'hC0);
    #1;
    chk_eq("full_block", ext_rsp_ready, 2'b00);
    chk_eq("full_busy", busy, 1);
    tick();
    commit_ready = 1;
    #1;
    chk_eq("full_block_on_pop", ext_rsp_ready, 2'b00);
    chk_eq("full_head", commit_uuid, 44'd100);
    tick();
    commit_ready = 0;
    #1;
    chk_eq("full_unblock", ext_rsp_ready, 2'b01);
    tick();
    ext_rsp_valid = 2'b00;
    commit_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_eq("drain_valid", commit_valid, 1);
      chk_eq("drain_uuid", commit_uuid, (i < 3) ? 44'(101 + i) : 44'd200);
      tick();
    end
    chk_eq("drain_empty", commit_valid, 0);
    commit_ready = 0;

    // reset mid-operation: channel 0 up to 3 credits, 3 wctl entries queued
    req_valid = 1; req_sel = 2'd0; ext_req_ready = 2'b01;
    tick(); tick();
    req_sel = 2'd2;
    tick(); tick(); tick();
    req_valid = 0;
    #1;
    chk_eq("mid_busy_before", busy, 1);
    chk_eq("mid_valid_before", commit_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    chk_eq("mid_commit_valid", commit_valid, 0);
    chk_eq("mid_busy", busy, 0);
    chk_eq("mid_ext_req_valid", ext_req_valid, 0);
    tick();
    reset = 1'b1;
    req_valid = 1; req_sel = 2'd0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_eq("post_rst_accept", req_ready, 1);
      tick();
    end
    #1;
    chk_eq("post_rst_limit", req_ready, 0);
    req_valid = 0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
